// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage owning the PC, instruction-memory address and IR, with next-PC and fetch trap logic.
// Optional macro IFETCH_COUNT_EN builds the IR-capture counter on fetch_cnt_o; TEXT_BASE mirrors `TEXT_BASE_ADDRESS.
`default_nettype none

module ifetch_unit #(
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req_i,
  input  logic        pc_wr_i,
  input  logic [1:0]  pc_src_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] target26_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] ins_data_i,
  output logic [31:0] ins_addr_o,
  output logic [31:0] ir_o,
  output logic        ir_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        busy_o,
  output logic        fault_o,
  output logic [31:0] fetch_cnt_o
);

  localparam logic [31:0] TEXT_BYTES = 32'(IMEM_WORDS * 4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_addr_q, ins_addr_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_off;
  logic        fetch_legal;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src_i)
      2'd0: next_pc = pc_plus4;
      2'd1: next_pc = pc_plus4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};
      2'd2: next_pc = {pc_plus4[31:28], target26_i, 2'b00};
      2'd3: next_pc = rs_val_i;
      default: next_pc = pc_plus4;
    endcase
  end

  // A same-cycle PC write redirects the fetch to the new PC; the unsigned
  // subtraction wraps addresses below TEXT_BASE into the out-of-range region.
  assign fetch_pc    = pc_wr_i ? next_pc : pc_q;
  assign fetch_off   = fetch_pc - TEXT_BASE;
  assign fetch_legal = (fetch_pc[1:0] == 2'b00) && (fetch_off < TEXT_BYTES);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ins_addr_d = ins_addr_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (pc_wr_i) begin
          pc_d       = next_pc;
          ir_valid_d = 1'b0;
        end
        if (fetch_req_i) begin
          ir_valid_d = 1'b0;
          if (fetch_legal) begin
            state_d    = S_FETCH;
            ins_addr_d = fetch_pc;
          end else begin
            state_d = S_FAULT;
            ir_d    = '0;
          end
        end
      end
      S_FETCH: begin
        ir_d       = ins_data_i;
        ir_valid_d = 1'b1;
        state_d    = S_HOLD;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ins_addr_q <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ins_addr_q <= ins_addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

`ifdef IFETCH_COUNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
    end else if (state_q == S_FETCH) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
`else
  assign fetch_cnt_o = '0;
`endif

  assign ins_addr_o = ins_addr_q;
  assign ir_o       = ir_q;
  assign ir_valid_o = ir_valid_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4;
  assign busy_o     = (state_q == S_FETCH);
  assign fault_o    = (state_q == S_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench for ifetch_unit with a behavioural instruction memory.
`default_nettype none

module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic        pc_wr = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic [15:0] imm16 = '0;
  logic [25:0] target26 = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] ins_data;
  logic [31:0] ins_addr, ir, pc, pc_plus4, fetch_cnt;
  logic        ir_valid, busy, fault;

  logic [31:0] mem [0:1023];
  logic [31:0] sb [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned exp_cnt = 0;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req_i (fetch_req),
    .pc_wr_i     (pc_wr),
    .pc_src_i    (pc_src),
    .imm16_i     (imm16),
    .target26_i  (target26),
    .rs_val_i    (rs_val),
    .ins_data_i  (ins_data),
    .ins_addr_o  (ins_addr),
    .ir_o        (ir),
    .ir_valid_o  (ir_valid),
    .pc_o        (pc),
    .pc_plus4_o  (pc_plus4),
    .busy_o      (busy),
    .fault_o     (fault),
    .fetch_cnt_o (fetch_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - 32'h3000;
    if (off < 32'd4096) return mem[off[11:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign ins_data = mem_word(ins_addr);

  function automatic logic [31:0] cnt_exp();
`ifdef IFETCH_COUNT_EN
    return exp_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_req = 1'b0;
    pc_wr     = 1'b0;
    pc_src    = 2'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_pc", pc, 32'h3000);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    step();
    rst = 1'b0;
    exp_cnt = 0;
    sb.delete();
  endtask

  // Legal fetch; optionally keeps fetch_req/pc_wr asserted during FETCH, which must be ignored.
  task automatic do_fetch(input logic wr, input logic [1:0] src, input logic [31:0] rs,
                          input logic [31:0] exp_pc, input bit poke);
    int lat;
    pc_wr = wr; pc_src = src; rs_val = rs; fetch_req = 1'b1;
    sb.push_back(mem_word(exp_pc));
    step();
    check("fetch_pc", pc, exp_pc);
    check("fetch_ins_addr", ins_addr, exp_pc);
    check("fetch_busy", {31'd0, busy}, 32'd1);
    check("fetch_ir_valid_low", {31'd0, ir_valid}, 32'd0);
    if (poke) begin
      pc_wr = 1'b1; pc_src = 2'd0;
    end else begin
      clear_inputs();
    end
    lat = 0;
    for (int k = 0; k < 4 && !ir_valid; k++) begin
      step();
      lat++;
    end
    clear_inputs();
    check("capture_latency", lat, 1);
    check("capture_ir_valid", {31'd0, ir_valid}, 32'd1);
    check("capture_busy", {31'd0, busy}, 32'd0);
    check("capture_pc_hold", pc, exp_pc);
    exp_cnt++;
    check("fetch_cnt", fetch_cnt, cnt_exp());
    if (sb.size() != 0) check("capture_ir", ir, sb.pop_front());
  endtask

  task automatic pc_update(input logic [1:0] src, input logic [15:0] imm, input logic [25:0] tgt,
                           input logic [31:0] rs, input logic [31:0] exp_pc);
    pc_wr = 1'b1; pc_src = src; imm16 = imm; target26 = tgt; rs_val = rs;
    step();
    clear_inputs();
    check("pcwr_pc", pc, exp_pc);
    check("pcwr_pc_plus4", pc_plus4, exp_pc + 32'd4);
    check("pcwr_ir_valid", {31'd0, ir_valid}, 32'd0);
  endtask

  task automatic do_fault(input logic wr, input logic [31:0] rs, input logic [31:0] exp_addr);
    pc_wr = wr; pc_src = 2'd3; rs_val = rs; fetch_req = 1'b1;
    step();
    clear_inputs();
    check("fault_flag", {31'd0, fault}, 32'd1);
    check("fault_busy", {31'd0, busy}, 32'd0);
    check("fault_ir", ir, 32'd0);
    check("fault_ir_valid", {31'd0, ir_valid}, 32'd0);
    check("fault_ins_addr", ins_addr, exp_addr);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = 32'h2008_0005;

    #12;
    check("reset_pc", pc, 32'h3000);
    check("reset_ins_addr", ins_addr, 32'h3000);
    check("reset_ir", ir, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_fetch_cnt", fetch_cnt, 32'd0);
    step();
    rst = 1'b0;
    step();

    do_fetch(1'b0, 2'd0, 32'd0, 32'h3000, 1'b0);
    do_fetch(1'b1, 2'd0, 32'd0, 32'h3004, 1'b0);

    pc_update(2'd3, 16'h0000, 26'h0, 32'h3010, 32'h3010);
    pc_update(2'd1, 16'hFFFC, 26'h0, 32'h0, 32'h3004);
    pc_update(2'd2, 16'h0000, 26'h0000C03, 32'h0, 32'h300C);
    do_fetch(1'b0, 2'd0, 32'd0, 32'h300C, 1'b1);

    do_fault(1'b1, 32'h3002, 32'h300C);
    pc_wr = 1'b1; pc_src = 2'd0; fetch_req = 1'b1;
    for (int k = 0; k < 3; k++) step();
    clear_inputs();
    check("sticky_pc", pc, 32'h3002);
    check("sticky_fault", {31'd0, fault}, 32'd1);
    check("sticky_ins_addr", ins_addr, 32'h300C);
    check("sticky_cnt", fetch_cnt, cnt_exp());
    do_reset();
    check("post_rst_fault", {31'd0, fault}, 32'd0);

    do_fault(1'b1, 32'h4000, 32'h3000);
    do_reset();
    do_fetch(1'b1, 2'd3, 32'h3FFC, 32'h3FFC, 1'b0);

    pc_update(2'd3, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    pc_update(2'd0, 16'h0, 26'h0, 32'h0, 32'h0);
    do_fault(1'b0, 32'h0, 32'h3FFC);
    do_reset();

    do_fetch(1'b0, 2'd0, 32'd0, 32'h3000, 1'b0);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_ir_valid", {31'd0, ir_valid}, 32'd0);
    check("abort_pc", pc, 32'h3000);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ir", ir, 32'd0);
    step();
    rst = 1'b0;
    exp_cnt = 0;
    step();
    step();
    check("abort_no_capture_ir", ir, 32'd0);
    check("abort_no_capture_valid", {31'd0, ir_valid}, 32'd0);
    check("abort_cnt", fetch_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
